// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that drains the read side of an asynchronous FIFO.
// It watches i_empty, latches i_rd_data and pulses o_r_inc once per word, then shifts the
// word out LSB first as a start/data/stop frame. All logic runs in the FIFO read clock domain.
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the
// stop bit (11-bit frame instead of 10).
module fifo_uart_tx #(
  parameter int unsigned width        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_empty,
  input  logic [width-1:0] i_rd_data,
  output logic             o_r_inc,
  output logic             o_tx_out,
  output logic             o_busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = $clog2(width) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(width - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e           r_state, w_state_next;
  logic [CntW-1:0]  r_cnt, w_cnt_next;
  logic [IdxW-1:0]  r_idx, w_idx_next;
  logic [width-1:0] r_shift, w_shift_next;
  logic [width-1:0] w_shift_shr;
  logic             r_tx, w_tx_next;
  logic             r_busy, w_busy_next;
  logic             r_rinc, w_rinc_next;
  logic             w_bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             r_parity, w_parity_next;
`endif

  assign w_bit_end   = (r_cnt == CntLast);
  assign w_shift_shr = r_shift >> 1;

  // Next-state and registered-output values; every frame field lasts CLKS_PER_BIT cycles.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_shift_next  = r_shift;
    w_tx_next     = r_tx;
    w_busy_next   = r_busy;
    w_rinc_next   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    unique case (r_state)
      StIdle: begin
        w_cnt_next  = '0;
        w_idx_next  = '0;
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        // Pop and start bit happen on the same edge: zero pop-to-line latency.
        if (i_en && !i_empty) begin
          w_shift_next  = i_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
          w_parity_next = ^i_rd_data;
`endif
          w_rinc_next   = 1'b1;
          w_tx_next     = 1'b0;
          w_busy_next   = 1'b1;
          w_state_next  = StStart;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_tx_next    = r_shift[0];
          w_state_next = StData;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_idx == IdxLast) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_tx_next    = r_parity;
            w_state_next = StParity;
`else
            w_tx_next    = 1'b1;
            w_state_next = StStop;
`endif
          end else begin
            // Shift so the next data bit is always at position 0.
            w_idx_next   = r_idx + 1'b1;
            w_shift_next = w_shift_shr;
            w_tx_next    = w_shift_shr[0];
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_tx_next    = 1'b1;
          w_state_next = StStop;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
`endif
      StStop: begin
        // Return to idle here; the next pop is evaluated one edge later, giving the idle cycle.
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_tx_next    = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_idx_next   = '0;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any partial frame immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_rinc   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
      r_busy   <= w_busy_next;
      r_rinc   <= w_rinc_next;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  assign o_r_inc  = r_rinc;
  assign o_tx_out = r_tx;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: a queue models the FIFO, and expected line waveforms are built
// from the frame definition (start 0, data LSB first, optional even parity, stop 1).
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int W  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int F  = 11;
`else
  localparam int F  = 10;
`endif
  localparam int FC = F * C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         empty = 1'b1;
  logic [W-1:0] rd_data = '0;
  logic         r_inc, tx, busy;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q[$];
  logic         tx_log[0:1023];
  logic         busy_log[0:1023];
  logic         rinc_log[0:1023];
  int           log_n;

  fifo_uart_tx #(
    .width       (W),
    .CLKS_PER_BIT(C)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_empty  (empty),
    .i_rd_data(rd_data),
    .o_r_inc  (r_inc),
    .o_tx_out (tx),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: a pop strobe removes the head word; flags/data follow the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (r_inc === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL pop_when_empty: r_inc=1 with empty FIFO, required no pop");
        end else begin
          void'(q.pop_front());
        end
      end
      empty   = (q.size() == 0);
      rd_data = empty ? '0 : q[0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Expected tx samples from the pop cycle: frame bits each held C cycles, then one idle high.
  function automatic logic [63:0] exp_line(input logic [W-1:0] w);
    logic [11:0] fb;
    logic [63:0] v;
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < W; i++) fb[i+1] = w[i];
`ifdef FIFO_UART_TX_PARITY_EN
    fb[W+1] = ^w;
`endif
    v = '0;
    for (int t = 0; t < FC; t++) v[t] = fb[t/C];
    v[FC] = 1'b1;
    return v;
  endfunction

  task automatic capture(input int n);
    log_n = 0;
    repeat (n) begin
      @(negedge clk);
      tx_log[log_n]   = tx;
      busy_log[log_n] = busy;
      rinc_log[log_n] = r_inc;
      log_n++;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] w;
    w   = 8'($urandom);
    rst = 1'b1;
    en  = 1'b1;
    q.push_back(w);
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b, required 1", tx); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++;
    if (r_inc !== 1'b0) begin fails++; $display("FAIL reset_rinc: got %b, required 0", r_inc); end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (r_inc !== 1'b1) begin fails++; $display("FAIL first_pop: r_inc %b, required 1", r_inc); end
    tests++;
    if (tx !== 1'b0) begin fails++; $display("FAIL first_start: tx %b, required 0", tx); end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL first_busy: busy %b, required 1", busy); end
    repeat (FC) @(negedge clk);
    tests++;
    if ({tx, busy} !== 2'b10) begin
      fails++;
      $display("FAIL first_frame_end: tx,busy=%b%b, required 10", tx, busy);
    end
  endtask

  task automatic test_single(input logic [W-1:0] w);
    int p, nb, nr;
    logic [63:0] obs, expv;
    p  = -1;
    nb = 0;
    nr = 0;
    q.push_back(w);
    capture(FC + 20);
    for (int i = 0; i < log_n; i++) begin
      if (rinc_log[i] === 1'b1) begin
        nr++;
        if (p < 0) p = i;
      end
      if (busy_log[i] === 1'b1) nb++;
    end
    tests++;
    if (nr !== 1) begin fails++; $display("FAIL single_rinc w=%02h: %0d pulses, required 1", w, nr); end
    tests++;
    if (nb !== FC) begin fails++; $display("FAIL single_busy w=%02h: %0d cycles, required %0d", w, nb, FC); end
    tests++;
    if (p < 0 || p + FC >= log_n) begin
      fails++;
      $display("FAIL single_window w=%02h: pop index %0d, required a full frame", w, p);
    end else begin
      obs = '0;
      for (int t = 0; t <= FC; t++) obs[t] = tx_log[p+t];
      expv = exp_line(w);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL single_line w=%02h: got %h, required %h", w, obs, expv);
      end
      tests++;
      if ({busy_log[p], busy_log[p+FC]} !== 2'b10) begin
        fails++;
        $display("FAIL single_busy_edges w=%02h: got %b%b, required 10", w, busy_log[p],
                 busy_log[p+FC]);
      end
    end
  endtask

  task automatic test_back_to_back(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                   input logic [W-1:0] w2);
    logic [W-1:0] ws[3];
    int pops[$];
    logic [63:0] obs, expv;
    ws[0] = w0;
    ws[1] = w1;
    ws[2] = w2;
    for (int j = 0; j < 3; j++) q.push_back(ws[j]);
    capture(3 * (FC + 1) + 20);
    for (int i = 0; i < log_n; i++) if (rinc_log[i] === 1'b1) pops.push_back(i);
    tests++;
    if (pops.size() !== 3) begin
      fails++;
      $display("FAIL b2b_pops: %0d pulses, required 3", pops.size());
    end
    for (int j = 0; j < pops.size() && j < 3; j++) begin
      tests++;
      if (pops[j] + FC >= log_n) begin
        fails++;
        $display("FAIL b2b_window%0d: pop index %0d, required a full frame", j, pops[j]);
      end else begin
        obs = '0;
        for (int t = 0; t <= FC; t++) obs[t] = tx_log[pops[j]+t];
        expv = exp_line(ws[j]);
        if (obs !== expv) begin
          fails++;
          $display("FAIL b2b_line%0d w=%02h: got %h, required %h", j, ws[j], obs, expv);
        end
      end
    end
    for (int j = 1; j < pops.size(); j++) begin
      tests++;
      if (pops[j] - pops[j-1] !== FC + 1) begin
        fails++;
        $display("FAIL b2b_spacing%0d: got %0d, required %0d", j, pops[j] - pops[j-1], FC + 1);
      end
    end
  endtask

  task automatic test_en_drop();
    logic [W-1:0] w0, w1;
    int p, nr, bad;
    bit dropped;
    logic [63:0] obs, expv;
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    p  = -1;
    nr = 0;
    bad = 0;
    dropped = 1'b0;
    q.push_back(w0);
    q.push_back(w1);
    en = 1'b1;
    log_n = 0;
    repeat (FC + 40) begin
      @(negedge clk);
      tx_log[log_n]   = tx;
      rinc_log[log_n] = r_inc;
      if (r_inc === 1'b1) begin
        nr++;
        if (p < 0) p = log_n;
      end
      // Drop enable in the middle of data bit 3.
      if (p >= 0 && !dropped && log_n == p + 4 * C + 1) begin
        en = 1'b0;
        dropped = 1'b1;
      end
      log_n++;
    end
    tests++;
    if (!dropped) begin
      fails++;
      $display("FAIL en_drop_pop: no pop seen, required one");
    end else begin
      obs = '0;
      for (int t = 0; t <= FC; t++) obs[t] = tx_log[p+t];
      expv = exp_line(w0);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL en_drop_line w=%02h: got %h, required %h", w0, obs, expv);
      end
      for (int i = p + FC; i < log_n; i++) if (tx_log[i] !== 1'b1) bad++;
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL en_drop_idle: %0d low samples, required 0", bad); end
    end
    tests++;
    if (nr !== 1) begin fails++; $display("FAIL en_drop_rinc: %0d pulses, required 1", nr); end
    tests++;
    if (q.size() !== 1) begin fails++; $display("FAIL en_drop_queue: %0d words left, required 1", q.size()); end
    q.delete();
    repeat (2) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w0, w1;
    bit found;
    int p, nr;
    logic [63:0] obs, expv;
    // Bit 5 forced to 0 so the line must visibly return high on reset.
    w0 = 8'($urandom) & 8'hDF;
    w1 = 8'($urandom);
    found = 1'b0;
    q.push_back(w0);
    q.push_back(w1);
    en = 1'b1;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (r_inc === 1'b1) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL rst_mid_pop: no pop within 50 cycles, required one");
      return;
    end
    repeat (6 * C + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({tx, busy, r_inc} !== 3'b100) begin
      fails++;
      $display("FAIL rst_mid_async: tx,busy,rinc=%b%b%b, required 100", tx, busy, r_inc);
    end
    @(negedge clk);
    rst = 1'b0;
    capture(FC + 20);
    p  = -1;
    nr = 0;
    for (int i = 0; i < log_n; i++) begin
      if (rinc_log[i] === 1'b1) begin
        nr++;
        if (p < 0) p = i;
      end
    end
    tests++;
    if (p !== 0) begin fails++; $display("FAIL rst_mid_repop: pop index %0d, required 0", p); end
    tests++;
    if (nr !== 1) begin fails++; $display("FAIL rst_mid_rinc: %0d pulses, required 1", nr); end
    if (p >= 0 && p + FC < log_n) begin
      obs = '0;
      for (int t = 0; t <= FC; t++) obs[t] = tx_log[p+t];
      expv = exp_line(w1);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL rst_mid_line w=%02h: got %h, required %h", w1, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'h07);
    for (int i = 0; i < 3; i++) test_single(8'($urandom));
    test_back_to_back(8'h01, 8'h02, 8'h03);
    test_back_to_back(8'($urandom), 8'($urandom), 8'($urandom));
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
